// File: rtl/sm83_alu_seq.sv
// Purpose: sequences one 8-bit ADD/ADC/SUB/SBC/CP through the companion 4-bit ALU as a low and a high nibble pass.
// Latency: done (and result_we for non-CP ops) pulses 6 cycles after the cycle in which start is accepted.
// Backpressure: a start while busy is dropped; a start in the done cycle is accepted with no idle gap.
module sm83_alu_seq (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [7:0] a_val,
   input  logic [7:0] b_val,
   input  logic       flags_we,
   input  logic [7:0] flags_in,
   output logic       busy,
   output logic       done,
   output logic       illegal,
   output logic [7:0] result,
   output logic       result_we,
   output logic [7:0] flags,
   output logic [7:0] alu_din,
   input  logic [7:0] alu_dout,
   input  logic       alu_carry,
   input  logic       alu_zero,
   output logic       alu_load_a,
   output logic       alu_load_b,
   output logic       alu_shift_oe,
   output logic       alu_result_oe,
   output logic       alu_op_low,
   output logic       alu_op_b_high,
   output logic       alu_negate,
   output logic       alu_carry_in,
   output logic       alu_shift_l,
   output logic       alu_shift_r,
   output logic       alu_no_carry_out,
   output logic       alu_force_carry,
   output logic       alu_ignore_carry,
   output logic       alu_op_a_oe,
   output logic       alu_bs_oe,
   output logic       alu_load_a_zero,
   output logic       alu_load_b_zero
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_CP  = 3'd4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDA  = 3'd1,
      LDB  = 3'd2,
      LO   = 3'd3,
      HI   = 3'd4,
      WB   = 3'd5
   } state_t;

   state_t     state, state_n;
   logic [2:0] op_q;
   logic       cin_lo;     // carry-in for the low nibble pass, fixed when the op is accepted
   logic       hc, cy;     // raw ALU carries out of the low and high nibble passes
   logic       fz, fn, fh, fc;
   logic       accept, reject;
   logic       op_sub;
   logic       op_legal;
   logic [3:0] unused_flags_lo;

   assign op_legal        = (op <= OP_CP);
   assign op_sub          = (op_q != OP_ADD) && (op_q != OP_ADC);
   assign flags           = {fz, fn, fh, fc, 4'b0000};
   assign unused_flags_lo = flags_in[3:0];

   // ALU features this sequencer never uses stay parked
   assign alu_shift_l      = 1'b0;
   assign alu_shift_r      = 1'b0;
   assign alu_no_carry_out = 1'b0;
   assign alu_force_carry  = 1'b0;
   assign alu_ignore_carry = 1'b0;
   assign alu_op_a_oe      = 1'b0;
   assign alu_bs_oe        = 1'b0;
   assign alu_load_a_zero  = 1'b0;
   assign alu_load_b_zero  = 1'b0;

   // Next state plus per-state ALU control decode
   always_comb begin
      state_n       = state;
      accept        = 1'b0;
      reject        = 1'b0;
      busy          = 1'b0;
      alu_din       = 8'h00;
      alu_load_a    = 1'b0;
      alu_load_b    = 1'b0;
      alu_shift_oe  = 1'b0;
      alu_result_oe = 1'b0;
      alu_op_low    = 1'b0;
      alu_op_b_high = 1'b0;
      alu_negate    = 1'b0;
      alu_carry_in  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op_legal) begin
                  accept  = 1'b1;
                  state_n = LDA;
               end else begin
                  reject  = 1'b1;
               end
            end
         end
         LDA: begin
            busy         = 1'b1;
            alu_din      = a_val;
            alu_shift_oe = 1'b1;
            alu_load_a   = 1'b1;
            state_n      = LDB;
         end
         LDB: begin
            busy         = 1'b1;
            alu_din      = b_val;
            alu_shift_oe = 1'b1;
            alu_load_b   = 1'b1;
            state_n      = LO;
         end
         LO: begin
            busy         = 1'b1;
            alu_op_low   = 1'b1;
            alu_negate   = op_sub;
            alu_carry_in = cin_lo;
            state_n      = HI;
         end
         HI: begin
            busy          = 1'b1;
            alu_op_b_high = 1'b1;
            alu_negate    = op_sub;
            alu_carry_in  = hc;
            state_n       = WB;
         end
         WB: begin
            busy          = 1'b1;
            alu_result_oe = 1'b1;
            state_n       = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // Operation context: op, low-pass carry-in and the two nibble carries
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q   <= OP_ADD;
         cin_lo <= 1'b0;
         hc     <= 1'b0;
         cy     <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= op;
            case (op)
               OP_ADC:  cin_lo <= fc;
               OP_SUB:  cin_lo <= 1'b1;
               OP_SBC:  cin_lo <= ~fc;
               OP_CP:   cin_lo <= 1'b1;
               default: cin_lo <= 1'b0;
            endcase
         end
         if (state == LO) hc <= alu_carry;
         if (state == HI) cy <= alu_carry;
      end
   end

   // Result register and single-cycle status pulses
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result    <= 8'h00;
         result_we <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         done      <= (state == WB);
         illegal   <= reject;
         result_we <= (state == WB) && (op_q != OP_CP);
         if ((state == WB) && (op_q != OP_CP)) result <= alu_dout;
      end
   end

   // Flag register: WB update, overridden by a direct load in the same cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         {fz, fn, fh, fc} <= 4'b0000;
      end else if (flags_we) begin
         {fz, fn, fh, fc} <= flags_in[7:4];
      end else if (state == WB) begin
         fz <= alu_zero;
         fn <= op_sub;
         fh <= op_sub ? ~hc : hc;
         fc <= op_sub ? ~cy : cy;
      end
   end

endmodule
